// File: rtl/biometrics_pkg.sv
// Shared types and helpers for the biometrics datapath blocks.
package biometrics_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENROLL,
      S_PREDICT,
      S_DISCARD,
      S_REDUCE,
      S_RESULT
   } state_e;

   // Working width of the generic absolute-difference helper.
   localparam int ABS_W = 64;

   // The accumulator can never overflow at this width: NUM_FEATURES terms,
   // each below 2**FEATURE_WIDTH.
   function automatic int dist_width(input int feature_width, input int num_features);
      return feature_width + 1 + $clog2(num_features);
   endfunction

   // |a - b| of two sign-extended operands.
   function automatic logic [ABS_W-1:0] abs_diff(input logic signed [ABS_W-1:0] a,
                                                 input logic signed [ABS_W-1:0] b);
      logic signed [ABS_W-1:0] d;
      d = a - b;
      return d[ABS_W-1] ? $unsigned(-d) : $unsigned(d);
   endfunction

endpackage

// File: rtl/voice_profile_matcher_if.sv
// Feature beat stream from feature_extractor into the profile matcher.
interface voice_profile_matcher_if #(
   parameter int FEATURE_WIDTH = 16
) ();
   logic signed [FEATURE_WIDTH-1:0] feature_data_in;
   logic                            feature_valid_in;
   logic                            feature_last_in;
   logic                            feature_ready_out;

   modport master (
      output feature_data_in,
      output feature_valid_in,
      output feature_last_in,
      input  feature_ready_out
   );

   modport slave (
      input  feature_data_in,
      input  feature_valid_in,
      input  feature_last_in,
      output feature_ready_out
   );
endinterface

// File: rtl/profile_bank.sv
// One template slot: feature memory plus its running L1 distance.
module profile_bank
   import biometrics_pkg::*;
#(
   parameter int FEATURE_WIDTH = 16,
   parameter int NUM_FEATURES  = 32,
   parameter int DIST_WIDTH    = dist_width(FEATURE_WIDTH, NUM_FEATURES)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              wr_en_i,
   input  logic [$clog2(NUM_FEATURES)-1:0]   wr_addr_i,
   input  logic [$clog2(NUM_FEATURES)-1:0]   rd_addr_i,
   input  logic signed [FEATURE_WIDTH-1:0]   sample_i,
   input  logic                              acc_en_i,
   input  logic                              acc_first_i,
   output logic [DIST_WIDTH-1:0]             dist_o
);
   localparam int DIFF_W = FEATURE_WIDTH + 1;

   logic signed [FEATURE_WIDTH-1:0] mem_q [NUM_FEATURES];
   logic signed [FEATURE_WIDTH-1:0] tmpl_q;
   logic [DIFF_W-1:0]               diff_w;
   logic [DIST_WIDTH-1:0]           dist_q;

   // Template storage with registered read. The top presents the address of
   // the next beat, so tmpl_q already holds template[k] when beat k arrives.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= sample_i;
      end
      tmpl_q <= mem_q[rd_addr_i];
   end

   // The magnitude of a difference of two FEATURE_WIDTH samples always fits
   // in FEATURE_WIDTH+1 bits.
   assign diff_w = DIFF_W'(abs_diff(ABS_W'(sample_i), ABS_W'(tmpl_q)));

   // Running distance; restarts on the first beat of each frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dist_q <= '0;
      end else if (acc_en_i) begin
         dist_q <= acc_first_i ? DIST_WIDTH'(diff_w) : dist_q + DIST_WIDTH'(diff_w);
      end
   end

   assign dist_o = dist_q;
endmodule

// File: rtl/voice_profile_matcher.sv
// Multi-owner voice profile matcher: enrolls templates and scores frames by L1 distance.
module voice_profile_matcher
   import biometrics_pkg::*;
#(
   parameter int NUM_PROFILES  = 4,
   parameter int NUM_FEATURES  = 32,
   parameter int FEATURE_WIDTH = 16,
   parameter int DIST_WIDTH    = dist_width(FEATURE_WIDTH, NUM_FEATURES),
   localparam int SLOT_W       = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   voice_profile_matcher_if.slave          feat,
   input  logic                            enroll_enable_in,
   input  logic [SLOT_W-1:0]               enroll_slot_in,
   input  logic                            predict_enable_in,
   input  logic                            clear_profiles_in,
   input  logic signed [FEATURE_WIDTH-1:0] loudness_threshold_in,
   input  logic [DIST_WIDTH-1:0]           distance_threshold_in,
   output logic [NUM_PROFILES-1:0]         profile_valid_out,
   output logic                            result_valid_out,
   output logic                            detected_out,
   output logic [SLOT_W-1:0]               match_id_out,
   output logic [DIST_WIDTH-1:0]           match_distance_out,
   output logic                            frame_error_out
);
   localparam int ADDR_W = $clog2(NUM_FEATURES);
   localparam int K_W    = $clog2(NUM_FEATURES + 1);
   localparam logic [K_W-1:0] K_NF   = K_W'(NUM_FEATURES);
   localparam logic [K_W-1:0] K_LAST = K_W'(NUM_FEATURES - 1);

   state_e                          state_q;
   logic [K_W-1:0]                  k_q, k_d;
   logic [SLOT_W-1:0]               slot_q;
   logic signed [FEATURE_WIDTH-1:0] peak_q;
   logic                            len_err_q;
   logic [NUM_PROFILES-1:0]         pv_q, pv_d, snap_q;
   logic [SLOT_W-1:0]               p_q, best_id_q, match_id_q;
   logic [DIST_WIDTH-1:0]           best_q, match_dist_q;
   logic                            any_q, detected_q, frame_err_q;

   logic                            ready_w, accept_w, first_w, last_w;
   logic                            is_enroll_w, is_predict_w, in_range_w, len_ok_w;
   logic [SLOT_W-1:0]               slot_sel_w;
   logic [ADDR_W-1:0]               rd_addr_w, wr_addr_w;
   logic                            acc_en_w, cand_valid_w, det_now_w;
   logic [DIST_WIDTH-1:0]           cand_dist_w;
   logic [NUM_PROFILES-1:0]         wr_en_w;
   logic [DIST_WIDTH-1:0]           dist_w [NUM_PROFILES];

   // Beat decode, next beat index, mask update and reducer candidate select.
   always_comb begin
      ready_w      = (state_q == S_IDLE) || (state_q == S_ENROLL) ||
                     (state_q == S_PREDICT) || (state_q == S_DISCARD);
      accept_w     = feat.feature_valid_in && ready_w;
      last_w       = feat.feature_last_in;
      first_w      = (state_q == S_IDLE);
      is_enroll_w  = first_w ? enroll_enable_in : (state_q == S_ENROLL);
      is_predict_w = first_w ? (!enroll_enable_in && predict_enable_in)
                             : (state_q == S_PREDICT);
      in_range_w   = (k_q < K_NF);
      len_ok_w     = (k_q == K_LAST);
      slot_sel_w   = first_w ? enroll_slot_in : slot_q;

      // k saturates at NUM_FEATURES so overlength frames stay detectable.
      k_d = k_q;
      if (accept_w) begin
         if (last_w)           k_d = '0;
         else if (k_q != K_NF) k_d = k_q + K_W'(1);
      end
      rd_addr_w = (k_d < K_NF) ? k_d[ADDR_W-1:0] : '0;
      wr_addr_w = k_q[ADDR_W-1:0];
      acc_en_w  = accept_w && is_predict_w && in_range_w;

      // A completing enrollment overrides a simultaneous clear for its slot.
      pv_d = clear_profiles_in ? '0 : pv_q;
      if (accept_w && is_enroll_w && last_w) begin
         for (int p = 0; p < NUM_PROFILES; p++) begin
            if (slot_sel_w == SLOT_W'(p)) pv_d[p] = len_ok_w;
         end
      end

      cand_dist_w  = '0;
      cand_valid_w = 1'b0;
      for (int p = 0; p < NUM_PROFILES; p++) begin
         if (p_q == SLOT_W'(p)) begin
            cand_dist_w  = dist_w[p];
            cand_valid_w = snap_q[p];
         end
      end

      det_now_w = any_q && (best_q <= distance_threshold_in) &&
                  (peak_q >= loudness_threshold_in) && !len_err_q;
   end

   generate
      for (genvar gi = 0; gi < NUM_PROFILES; gi++) begin : g_bank
         assign wr_en_w[gi] = accept_w && is_enroll_w && in_range_w &&
                              (slot_sel_w == SLOT_W'(gi));
         profile_bank #(
            .FEATURE_WIDTH(FEATURE_WIDTH),
            .NUM_FEATURES (NUM_FEATURES),
            .DIST_WIDTH   (DIST_WIDTH)
         ) u_bank (
            .clk_i      (clk_in),
            .rst_i      (rst_in),
            .wr_en_i    (wr_en_w[gi]),
            .wr_addr_i  (wr_addr_w),
            .rd_addr_i  (rd_addr_w),
            .sample_i   (feat.feature_data_in),
            .acc_en_i   (acc_en_w),
            .acc_first_i(first_w),
            .dist_o     (dist_w[gi])
         );
      end
   endgenerate

   // Frame FSM with peak tracker, sequential min-distance reducer and held results.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         slot_q       <= '0;
         peak_q       <= '0;
         len_err_q    <= 1'b0;
         pv_q         <= '0;
         snap_q       <= '0;
         p_q          <= '0;
         best_q       <= '0;
         best_id_q    <= '0;
         any_q        <= 1'b0;
         match_id_q   <= '0;
         match_dist_q <= '0;
         detected_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         k_q         <= k_d;
         pv_q        <= pv_d;
         case (state_q)
            S_IDLE, S_ENROLL, S_PREDICT, S_DISCARD: begin
               if (accept_w) begin
                  if (first_w) begin
                     slot_q    <= enroll_slot_in;
                     peak_q    <= feat.feature_data_in;
                     len_err_q <= 1'b0;
                  end else if (is_predict_w && in_range_w && feat.feature_data_in > peak_q) begin
                     peak_q <= feat.feature_data_in;
                  end
                  if (last_w) begin
                     if (is_enroll_w) begin
                        frame_err_q <= !len_ok_w;
                        state_q     <= S_IDLE;
                     end else if (is_predict_w) begin
                        frame_err_q <= !len_ok_w;
                        len_err_q   <= !len_ok_w;
                        snap_q      <= pv_q;
                        p_q         <= '0;
                        best_q      <= '0;
                        best_id_q   <= '0;
                        any_q       <= 1'b0;
                        state_q     <= S_REDUCE;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else if (is_enroll_w) begin
                     state_q <= S_ENROLL;
                  end else if (is_predict_w) begin
                     state_q <= S_PREDICT;
                  end else begin
                     state_q <= S_DISCARD;
                  end
               end
            end
            S_REDUCE: begin
               // Strict less-than keeps the lowest index on ties.
               if (cand_valid_w && (!any_q || cand_dist_w < best_q)) begin
                  best_q    <= cand_dist_w;
                  best_id_q <= p_q;
                  any_q     <= 1'b1;
               end
               if (p_q == SLOT_W'(NUM_PROFILES - 1)) state_q <= S_RESULT;
               else                                  p_q     <= p_q + SLOT_W'(1);
            end
            S_RESULT: begin
               match_id_q   <= best_id_q;
               match_dist_q <= best_q;
               detected_q   <= det_now_w;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // During RESULT the fresh decision is shown directly so thresholds are
   // sampled in that cycle; afterwards the held copies are presented.
   assign feat.feature_ready_out = ready_w;
   assign result_valid_out       = (state_q == S_RESULT);
   assign detected_out           = (state_q == S_RESULT) ? det_now_w : detected_q;
   assign match_id_out           = (state_q == S_RESULT) ? best_id_q : match_id_q;
   assign match_distance_out     = (state_q == S_RESULT) ? best_q : match_dist_q;
   assign profile_valid_out      = pv_q;
   assign frame_error_out        = frame_err_q;
endmodule
